// File: rtl/decoder_ctrl_pkg.sv
// Shared types and helpers for the LED decoder sequencer.
// Covers the mode encoding, the ping-pong direction flag and the per-step next-state helpers.
package decoder_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'b00,
        MODE_SCAN     = 2'b01,
        MODE_PINGPONG = 2'b10
    } mode_e;

    localparam logic       DIR_UP   = 1'b0;
    localparam logic       DIR_DOWN = 1'b1;
    localparam logic [1:0] SEL_MAX  = 2'd3;

    // Button-driven cycle MANUAL -> SCAN -> PINGPONG -> MANUAL; anything else recovers to MANUAL.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_MANUAL:   nxt = MODE_SCAN;
            MODE_SCAN:     nxt = MODE_PINGPONG;
            MODE_PINGPONG: nxt = MODE_MANUAL;
            default:       nxt = MODE_MANUAL;
        endcase
        return nxt;
    endfunction

    // One bounce step: returns {next_dir, next_sel}; the direction flips on reaching an endpoint.
    function automatic logic [2:0] pingpong_next(input logic [1:0] sel, input logic dir);
        logic [1:0] nsel;
        logic       ndir;
        if (dir == DIR_UP) begin
            nsel = sel + 2'd1;
            if (nsel == SEL_MAX) begin
                ndir = DIR_DOWN;
            end else begin
                ndir = DIR_UP;
            end
        end else begin
            nsel = sel - 2'd1;
            if (nsel == 2'd0) begin
                ndir = DIR_UP;
            end else begin
                ndir = DIR_DOWN;
            end
        end
        return {ndir, nsel};
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-level filter for one raw pad input.
// The output takes a new level only after DEB_CYCLES consecutive differing samples.
module sync_debounce #(
    parameter int DEB_CYCLES = 120000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int             CW       = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchronizer, count runs of samples that disagree with the stable level.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // State registers with asynchronous reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Select/enable sequencer for the 2-to-4 LED decoder: manual, scan and ping-pong modes,
// cycled by a debounced push-button.
module decoder_scan_ctrl
    import decoder_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 6000000,
    parameter int DEB_CYCLES = 120000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sw,
    input  logic       mode_btn,
    output logic [1:0] sel,
    output logic       dec_en,
    output logic [1:0] mode,
    output logic       step
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [1:0] sw_db_s;
    logic       btn_db_s;
    logic       btn_rise_s;
    logic       tick_s;
    logic [2:0] pp_next_s;

    mode_e         mode_q, mode_d;
    logic [1:0]    sel_q, sel_d;
    logic          dir_q, dir_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          step_q, step_d;
    logic          dec_en_q, dec_en_d;
    logic          btn_prev_q, btn_prev_d;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw0 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw[0]),
        .dout  (sw_db_s[0])
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw1 (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw[1]),
        .dout  (sw_db_s[1])
    );

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mode_btn),
        .dout  (btn_db_s)
    );

    // Next-state for mode, prescaler, select, direction and the step pulse.
    always_comb begin
        btn_rise_s = btn_db_s & ~btn_prev_q;
        tick_s     = ((mode_q == MODE_SCAN) || (mode_q == MODE_PINGPONG)) && (presc_q == PRESC_LAST);
        pp_next_s  = pingpong_next(sel_q, dir_q);

        mode_d     = mode_q;
        sel_d      = sel_q;
        dir_d      = dir_q;
        presc_d    = presc_q;
        step_d     = 1'b0;
        dec_en_d   = 1'b1;
        btn_prev_d = btn_db_s;

        case (mode_q)
            MODE_MANUAL, MODE_SCAN, MODE_PINGPONG: begin
                if (btn_rise_s) begin
                    mode_d = next_mode(mode_q);
                end else begin
                    mode_d = mode_q;
                end
            end
            default: mode_d = MODE_MANUAL;
        endcase

        // A mode change overrides any tick landing in the same cycle.
        if (mode_d != mode_q) begin
            presc_d = '0;
            dir_d   = DIR_UP;
            if (mode_d == MODE_MANUAL) begin
                sel_d = sw_db_s;
            end else begin
                sel_d = 2'b00;
            end
        end else if (mode_q == MODE_MANUAL) begin
            presc_d = '0;
            sel_d   = sw_db_s;
        end else if (tick_s) begin
            presc_d = '0;
            step_d  = 1'b1;
            if (mode_q == MODE_SCAN) begin
                sel_d = sel_q + 2'd1;
            end else begin
                sel_d = pp_next_s[1:0];
                dir_d = pp_next_s[2];
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_MANUAL;
            sel_q      <= 2'b00;
            dir_q      <= DIR_UP;
            presc_q    <= '0;
            step_q     <= 1'b0;
            dec_en_q   <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            presc_q    <= presc_d;
            step_q     <= step_d;
            dec_en_q   <= dec_en_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign sel    = sel_q;
    assign dec_en = dec_en_q;
    assign mode   = mode_q;
    assign step   = step_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomized self-checking bench for decoder_scan_ctrl against a behavioural model,
// plus directed literal checks of latency, sequences and reset behaviour.
module tb_decoder_scan_ctrl;

    localparam int TICK = 4;
    localparam int DEB  = 3;
    localparam logic [1:0] PP_SEQ [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sw = 2'b10;
    logic       mode_btn = 1'b0;
    logic [1:0] sel;
    logic       dec_en;
    logic [1:0] mode;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    decoder_scan_ctrl #(.TICK_DIV(TICK), .DEB_CYCLES(DEB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw       (sw),
        .mode_btn (mode_btn),
        .sel      (sel),
        .dec_en   (dec_en),
        .mode     (mode),
        .step     (step)
    );

    always #5 clk = ~clk;

    // Model state: raw history models the synchronizer, window holds the last DEB synced samples.
    logic [2:0] raw_q [$];
    logic [2:0] win [$];
    logic [1:0] m_sw_db;
    logic       m_btn_db, m_btn_prev;
    int         m_mode, m_idx, m_phase;
    logic [1:0] m_sel;
    logic       m_step, m_en;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        raw_q.delete();
        raw_q.push_back(3'b000);
        raw_q.push_back(3'b000);
        win.delete();
        for (int i = 0; i < DEB; i++) win.push_back(3'b000);
        m_sw_db = 2'b00; m_btn_db = 1'b0; m_btn_prev = 1'b0;
        m_mode = 0; m_idx = 0; m_phase = 0;
        m_sel = 2'b00; m_step = 1'b0; m_en = 1'b0;
    endtask

    task automatic m_advance();
        logic [2:0] smp, cur;
        logic       press, tick, all_diff;
        raw_q.push_back({mode_btn, sw});
        smp   = raw_q.pop_front();
        press = m_btn_db && !m_btn_prev;
        tick  = (m_mode != 0) && (m_phase == TICK - 1);
        m_en  = 1'b1;
        if (press) begin
            m_mode  = (m_mode + 1) % 3;
            m_idx   = 0;
            m_phase = 0;
            m_step  = 1'b0;
            m_sel   = (m_mode == 0) ? m_sw_db : 2'd0;
        end else if (m_mode == 0) begin
            m_sel   = m_sw_db;
            m_step  = 1'b0;
            m_phase = 0;
        end else begin
            m_step = tick;
            if (tick) begin
                m_idx   = m_idx + 1;
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
            m_sel = (m_mode == 1) ? 2'(m_idx % 4) : PP_SEQ[m_idx % 6];
        end
        m_btn_prev = m_btn_db;
        win.push_back(smp);
        void'(win.pop_front());
        cur = {m_btn_db, m_sw_db};
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            foreach (win[i]) if (win[i][b] == cur[b]) all_diff = 1'b0;
            if (all_diff) cur[b] = ~cur[b];
        end
        {m_btn_db, m_sw_db} = cur;
    endtask

    // Model advances on each clock edge; reset is asynchronous as in the design.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_advance();
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("m_sel",    8'(sel),    8'(m_sel));
        chk("m_dec_en", 8'(dec_en), 8'(m_en));
        chk("m_mode",   8'(mode),   8'(m_mode));
        chk("m_step",   8'(step),   8'(m_step));
    end

    task automatic wait_step(output logic [1:0] s, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (step !== 1'b1 && n < 40);
        s = sel;
    endtask

    task automatic press_check(input logic [1:0] exp_mode, input logic [1:0] exp_sel, input string tag);
        mode_btn = 1'b1;
        repeat (6) @(negedge clk);
        chk({tag, "_mode"}, 8'(mode), 8'(exp_mode));
        chk({tag, "_sel"},  8'(sel),  8'(exp_sel));
        chk({tag, "_step"}, 8'(step), 8'h00);
        mode_btn = 1'b0;
    endtask

    logic [1:0] scan_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [1:0] pp_exp   [7] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

    initial begin
        logic [1:0] s;
        int         gap;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_sel",    8'(sel),    8'h00);
        chk("rst_dec_en", 8'(dec_en), 8'h00);
        chk("rst_mode",   8'(mode),   8'h00);
        chk("rst_step",   8'(step),   8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("en_first_edge", 8'(dec_en), 8'h01);
        repeat (4) @(negedge clk);
        chk("sel_before_deb", 8'(sel), 8'h00);
        @(negedge clk);
        chk("sel_after_deb", 8'(sel), 8'h02);

        sw = 2'b11;
        repeat (2) @(negedge clk);
        sw = 2'b10;
        repeat (8) @(negedge clk);
        chk("glitch_reject", 8'(sel), 8'h02);
        sw = 2'b01;
        repeat (5) @(negedge clk);
        chk("sw01_before", 8'(sel), 8'h02);
        @(negedge clk);
        chk("sw01_after", 8'(sel), 8'h01);

        press_check(2'b01, 2'b00, "to_scan");
        for (int i = 0; i < 4; i++) begin
            wait_step(s, gap);
            chk("scan_gap", 8'(gap), 8'd4);
            chk("scan_sel", 8'(s), 8'(scan_exp[i]));
        end

        press_check(2'b10, 2'b00, "to_pp");
        for (int i = 0; i < 7; i++) begin
            wait_step(s, gap);
            chk("pp_gap", 8'(gap), 8'd4);
            chk("pp_sel", 8'(s), 8'(pp_exp[i]));
        end

        press_check(2'b00, 2'b01, "to_manual");
        repeat (8) @(negedge clk);
        press_check(2'b01, 2'b00, "to_scan2");
        wait_step(s, gap);
        wait_step(s, gap);
        // Tick lands on edge T+4k; drive now so the debounced rise hits T+8.
        repeat (2) @(negedge clk);
        press_check(2'b10, 2'b00, "aligned");
        wait_step(s, gap);
        chk("aligned_restart_gap", 8'(gap), 8'd4);
        chk("aligned_first_sel",   8'(s),   8'h01);
        for (int i = 0; i < 3; i++) wait_step(s, gap);
        chk("pp_down_sel", 8'(s), 8'h02);

        #2 rst_n = 1'b0;
        #1;
        chk("async_sel",    8'(sel),    8'h00);
        chk("async_mode",   8'(mode),   8'h00);
        chk("async_dec_en", 8'(dec_en), 8'h00);
        chk("async_step",   8'(step),   8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("resume_mode",   8'(mode),   8'h00);
        chk("resume_dec_en", 8'(dec_en), 8'h01);
        chk("resume_sel",    8'(sel),    8'h01);

        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 39);
            if (r < 18) begin
                sw = 2'($urandom);
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end else if (r < 38) begin
                mode_btn = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                mode_btn = 1'b0;
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end else begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
